negate_serial: RTL
==================

NEGATE_SERIAL -- requirements
Module: negate_serial

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream has an operand on in_data.
REQ-005 Port: in_data  input  WIDTH  bitwise-inverted operand (~a) from the upstream inverter stage.
REQ-006 Port: in_ready  output  1  block can accept an operand.
REQ-007 Port: out_valid  output  1  out_data, carry_out and overflow hold a completed result.
REQ-008 Port: out_ready  input  1  downstream accepts the result.
REQ-009 Port: out_data  output  WIDTH  in_data + 1, modulo 2^WIDTH, equal to the two's-complement negation of a.
REQ-010 Port: carry_out  output  1  carry out of the MSB of in_data + 1.
REQ-011 Port: overflow  output  1  signed overflow of in_data + 1, i.e. a was the most negative value.
REQ-012 Port: busy  output  1  high while a serial computation is in progress.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-014 In IDLE the block SHALL drive in_ready=1; in BUSY and DONE it SHALL drive in_ready=0.
REQ-015 Acceptance SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 On acceptance the block SHALL load in_data into a shift register, set the carry to 1, clear the bit counter and enter BUSY.
REQ-017 Each BUSY cycle SHALL process one bit, LSB first: sum = bit XOR carry; carry = bit AND carry; the sum is shifted into the result register.
REQ-018 The bit counter SHALL count 0..WIDTH-1, and BUSY SHALL last exactly WIDTH cycles.
REQ-019 On the edge that processes bit WIDTH-1 the block SHALL:
- load out_data with the full result;
- set carry_out to the final carry;
- set overflow = (carry into MSB) XOR (carry out of MSB);
- enter DONE.
REQ-020 out_valid SHALL first be high WIDTH rising edges after the acceptance edge, giving a latency of WIDTH cycles.
REQ-021 out_valid SHALL be 1 only in DONE, and busy SHALL be 1 only in BUSY.
REQ-022 In DONE, out_data, carry_out and overflow SHALL remain stable until the rising edge where out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-023 After the DONE handshake, out_valid SHALL drop and in_ready SHALL rise on the same edge; a new operand is accepted no earlier than the following edge, giving a throughput of one result per WIDTH+2 cycles minimum.
REQ-024 in_valid asserted during BUSY or DONE SHALL be ignored, and upstream SHALL hold in_data until it is accepted.
REQ-025 Outside DONE, out_data, carry_out and overflow SHALL hold the last completed result, and SHALL NOT change while BUSY.
REQ-026 If out_ready is already 1 when DONE is entered, the block SHALL still hold DONE for at least one cycle.
REQ-027 Boundary: in_data=all-ones SHALL give out_data=0, carry_out=1, overflow=0.
REQ-028 Boundary: in_data=0 followed by 1s in the remaining bits (0x7F for WIDTH=8) SHALL give out_data=MSB-only (0x80), carry_out=0, overflow=1.

Reset
REQ-029 While rst_n=0 on a rising edge, the block SHALL enter IDLE and clear the following to 0: bit counter, shift register, out_data, carry_out, overflow, out_valid, busy.
REQ-030 After reset, in_ready SHALL be 1 from the edge on which reset is applied.
REQ-031 Reset asserted during BUSY or DONE SHALL abort the operation and discard the partial or pending result, with no out_valid pulse.
REQ-032 On the first edge with rst_n=1, the block SHALL be able to accept an operand.

Verification
REQ-033 in_data=0xFF (a=0x00), out_ready=1 -> out_valid rises 8 cycles after acceptance; out_data=0x00, carry_out=1, overflow=0.
REQ-034 in_data=0x52 (a=0xAD) -> out_data=0x53, carry_out=0, overflow=0; in_data=0x29 (a=0xD6) -> out_data=0x2A.
REQ-035 in_data=0x7F (a=0x80) -> out_data=0x80, carry_out=0, overflow=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with 0x00 meanwhile -> out_data stays stable, in_ready=0 and the new operand is not accepted; out_ready=1 -> IDLE on the next edge.
REQ-037 Reset mid-operation: drive rst_n=0 on the 4th BUSY cycle -> on the next edge busy=0, in_ready=1 and all outputs are 0; a fresh operand 0xFE then gives out_data=0xFF.
REQ-038 Back-to-back: two operands with in_valid held high and out_ready=1 -> accepted exactly WIDTH+2 edges apart, with results in order.

Source files
------------

// File: rtl/negate_serial.sv
// rtl/negate_serial.sv - bit-serial two's-complement negation (~a + 1), LSB first
// Three-state handshake FSM; results held stable until the downstream accepts them.
module negate_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sum;
  logic             carry_nxt;

  // One half-adder step of the +1 ripple, seeded with carry=1 on acceptance.
  always_comb begin
    sum       = sreg[0] ^ carry;
    carry_nxt = sreg[0] & carry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sreg      <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      out_data  <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sreg     <= in_data;
            carry    <= 1'b1;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          sreg  <= sreg >> 1;
          res   <= {sum, res[WIDTH-1:1]};
          carry <= carry_nxt;
          cnt   <= cnt + 1'b1;
          // Carry into the MSB is the carry held while processing the last bit.
          if (cnt == LAST) begin
            out_data  <= {sum, res[WIDTH-1:1]};
            carry_out <= carry_nxt;
            overflow  <= carry ^ carry_nxt;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
